serial_full_adder: RTL and testbench
====================================

// Module: serial_full_adder
// PURPOSE
//  Multi-cycle ripple adder: A + B + Cin computed BITS_PER_CYCLE bits per clock, LSB first.
//  A registered carry flop links the chunks.
//  Addition counterpart of the combinational 8-bit borrow-ripple subtractor in the ALU datapath.
//  Trades latency for area.
//  Valid/ready handshake on both sides; sits between the ALU operand registers and the result mux.
// PARAMETERS
//  WIDTH           8  operand/result width in bits
//  BITS_PER_CYCLE  1  bits added per clock; must divide WIDTH (1, 2, 4 or 8 at WIDTH=8)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands A, B, Cin present
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  A          in   WIDTH  augend, sampled on input handshake
//  B          in   WIDTH  addend, sampled on input handshake
//  Cin        in   1      carry in, sampled on input handshake
//  out_valid  out  1      Sum/Cout/Ovf valid
//  out_ready  in   1      consumer takes result
//  Sum        out  WIDTH  A + B + Cin, modulo 2^WIDTH
//  Cout       out  1      unsigned carry out of bit WIDTH-1
//  Ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - FSM states: IDLE, RUN, DONE. Define N = WIDTH/BITS_PER_CYCLE.
//  - Reset (async, any state): state=IDLE, chunk counter=0, carry flop=0, Sum=0, Cout=0, Ovf=0, out_valid=0.
//    in_ready=1 while in IDLE, including during reset.
//  - in_ready = (state==IDLE); out_valid = (state==DONE). Both decoded from state only.
//  - IDLE: on in_valid & in_ready at edge E0, latch A, B into shift registers and Cin into the carry flop.
//    Clear the counter; go to RUN.
//  - RUN: each edge adds the low BITS_PER_CYCLE bits of A, B plus carry, and shifts the result chunk into Sum from the MSB side.
//    Updates the carry flop; increments the counter.
//  - RUN exit: on the edge where counter reaches N-1, go to DONE.
//    Result is registered; out_valid=1 in the cycle after edge E0+N (latency N cycles from accept).
//  - Cout is the final carry. Ovf is captured from the carry into the top bit during the last chunk.
//  - DONE: Sum, Cout, Ovf held stable while out_valid=1 and out_ready=0.
//    On out_valid & out_ready, go to IDLE; in_ready=1 the next cycle.
//  - No back-to-back overlap: a new operand is accepted no earlier than 1 cycle after result handoff.
//  - in_valid outside IDLE: ignored. Operand changes during RUN/DONE have no effect.
//  - Sum/Cout/Ovf keep the last result in IDLE until the next RUN starts overwriting Sum.
//    Only values present while out_valid=1 are defined.
//  - Reset mid-RUN or mid-DONE: computation is abandoned and the result is discarded; all outputs go to reset values immediately.
//  - Carry chain wraps nowhere: carry out of the final chunk goes to Cout only and is not fed back.
// TESTING
//  1. A=8'h7F B=8'h01 Cin=0 -> Sum=8'h80 Cout=0 Ovf=1; out_valid rises exactly 8 cycles after accept (BITS_PER_CYCLE=1).
//  2. A=8'hFF B=8'h01 Cin=0 -> Sum=8'h00 Cout=1 Ovf=0. A=8'h00 B=8'hFF Cin=1 -> Sum=8'h00 Cout=1 Ovf=0.
//  3. A=8'h80 B=8'h80 Cin=0 with out_ready held low 5 cycles.
//     -> Sum=8'h00 Cout=1 Ovf=1 stable for all 5 cycles.
//     in_valid pulses during the wait are ignored; in_ready=1 one cycle after out_ready rises.
//  4. Assert rst during the 4th RUN cycle of A=8'h55 B=8'h2A.
//     -> out_valid=0, Sum=0, in_ready=1 immediately.
//     Next op A=8'h01 B=8'h02 -> Sum=8'h03.
//  5. BITS_PER_CYCLE=4: A=8'h9C B=8'h67 Cin=1 -> Sum=8'h04 Cout=1 Ovf=0, latency 2 cycles.
//  6. 10k random A/B/Cin with random out_ready stalls (BITS_PER_CYCLE 1, 2, 8).
//     -> {Cout,Sum} == A+B+Cin; Ovf matches the signed reference model; no result lost or duplicated.

Source files
------------

// File: rtl/serial_full_adder.sv
// Multi-cycle ripple adder: A + B + Cin computed BITS_PER_CYCLE bits per clock, LSB first.
// Latency WIDTH/BITS_PER_CYCLE cycles from accept; result held in DONE until out_ready, one op in flight.
module serial_full_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state, state_nxt;
  logic [CW-1:0]                   cnt;
  logic [WIDTH-1:0]                a_sh, b_sh;
  logic                            carry;
  logic [BITS_PER_CYCLE-1:0]       a_lo, b_lo, s_lo;
  logic                            c_lo, c_msb, last;
  logic [WIDTH+BITS_PER_CYCLE-1:0] sum_cat;

  assign a_lo = a_sh[BITS_PER_CYCLE-1:0];
  assign b_lo = b_sh[BITS_PER_CYCLE-1:0];
  assign {c_lo, s_lo} = {1'b0, a_lo} + {1'b0, b_lo} + {{BITS_PER_CYCLE{1'b0}}, carry};
  // A sum bit is a^b^cin, so the carry into the chunk's top bit falls out of the sum bit.
  assign c_msb   = s_lo[BITS_PER_CYCLE-1] ^ a_lo[BITS_PER_CYCLE-1] ^ b_lo[BITS_PER_CYCLE-1];
  assign last    = (cnt == CW'(N - 1));
  assign sum_cat = {s_lo, Sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> BITS_PER_CYCLE;
          b_sh  <= b_sh >> BITS_PER_CYCLE;
          carry <= c_lo;
          cnt   <= cnt + 1'b1;
          Sum   <= sum_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
          // Final carry leaves through Cout only; it never re-enters the chain.
          if (last) begin
            Cout <= c_lo;
            Ovf  <= c_msb ^ c_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_adder.sv
// Bench for serial_full_adder: directed corner cases at 1 and 4 bits/cycle,
// randomized scoreboard runs at 1, 2 and 8 bits/cycle with random output stalls.
module tb_serial_full_adder;

  localparam int LIMIT = 80000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rand_go = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] t;
    logic       o;
    t = {1'b0, a} + {1'b0, b} + {8'b0, c};
    o = (a[7] == b[7]) && (t[7] != a[7]);
    return {o, t[8], t[7:0]};
  endfunction

  // BITS_PER_CYCLE=1 instance: directed tests and random run
  logic       iv1, ir1, c1, ov1, or1, co1, of1;
  logic [7:0] a1, b1, s1;
  serial_full_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1), .Cin(c1),
    .out_valid(ov1), .out_ready(or1), .Sum(s1), .Cout(co1), .Ovf(of1));

  // BITS_PER_CYCLE=4 instance: directed test only
  logic       iv4, ir4, c4, ov4, or4, co4, of4;
  logic [7:0] a4, b4, s4;
  serial_full_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .Cin(c4),
    .out_valid(ov4), .out_ready(or4), .Sum(s4), .Cout(co4), .Ovf(of4));

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int BPC = (gi == 0) ? 2 : 8;
    logic       iv, ir, c, ov, orr, co, of;
    logic [7:0] a, b, s;
    logic [9:0] q[$];
    bit         done_f = 1'b0;

    serial_full_adder #(.WIDTH(8), .BITS_PER_CYCLE(BPC)) u (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .A(a), .B(b), .Cin(c),
      .out_valid(ov), .out_ready(orr), .Sum(s), .Cout(co), .Ovf(of));

    initial begin : drv
      int n, cyc;
      iv = 1'b0; a = '0; b = '0; c = 1'b0;
      wait (rand_go);
      n = 0; cyc = 0;
      while (n < 4000 && cyc < LIMIT) begin
        @(posedge clk); #1;
        iv = 1'($urandom_range(0, 1)); a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
        @(negedge clk);
        if (iv && ir) begin
          q.push_back(model(a, b, c));
          n++;
        end
        cyc++;
      end
      @(posedge clk); #1 iv = 1'b0;
    end

    initial begin : mon
      int got, cyc;
      logic [9:0] e;
      orr = 1'b0;
      wait (rand_go);
      got = 0; cyc = 0;
      while (got < 4000 && cyc < LIMIT) begin
        @(posedge clk); #1;
        orr = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (ov && orr) begin
          if (q.size() == 0) check_val($sformatf("rand_bpc%0d_extra", BPC), 1, 0);
          else begin
            e = q.pop_front();
            check_val($sformatf("rand_bpc%0d", BPC), {of, co, s}, e);
          end
          got++;
        end
        cyc++;
      end
      check_val($sformatf("rand_bpc%0d_count", BPC), got, 4000);
      @(posedge clk); #1 orr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val($sformatf("rand_bpc%0d_left", BPC), {q.size(), ov}, {32'd0, 1'b0} >> 1);
      done_f = 1'b1;
    end
  end

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int stall, input logic [7:0] es, input logic ec, input logic eo,
                        input int elat);
    int k;
    @(posedge clk); #1;
    iv1 = 1'b1; a1 = a; b1 = b; c1 = c; or1 = 1'b0;
    @(negedge clk);
    check_val({tag, "_inrdy"}, ir1, 1);
    @(posedge clk); #1;
    iv1 = 1'b0; a1 = ~a; b1 = ~b; c1 = ~c;
    k = 0;
    do begin
      @(posedge clk); k++;
      @(negedge clk);
    end while (!ov1 && k < 40);
    check_val({tag, "_lat"}, k, elat);
    check_val({tag, "_res"}, {eo, ec, s1 ^ s1 ^ es} == {of1, co1, s1}, 1);
    repeat (stall) begin
      @(posedge clk); #1;
      iv1 = 1'($urandom_range(0, 1)); a1 = 8'($urandom); b1 = 8'($urandom);
      @(negedge clk);
      check_val({tag, "_hold"}, {ir1, ov1, of1, co1, s1}, {1'b0, 1'b1, eo, ec, es});
    end
    @(posedge clk); #1;
    iv1 = 1'b0; or1 = 1'b1;
    @(posedge clk); #1 or1 = 1'b0;
    @(negedge clk);
    check_val({tag, "_handoff"}, {ir1, ov1}, 2'b10);
  endtask

  initial begin : main
    logic [9:0] q1[$];
    int k;
    iv1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; or1 = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; or4 = 1'b0;

    @(negedge clk);
    check_val("reset", {ir1, ov1, co1, of1, s1}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk) rst = 1'b0;

    run_op("t1",   8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1, 8);
    run_op("t2a",  8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0, 8);
    run_op("t2b",  8'h00, 8'hFF, 1'b1, 0, 8'h00, 1'b1, 1'b0, 8);
    run_op("t3",   8'h80, 8'h80, 1'b0, 5, 8'h00, 1'b1, 1'b1, 8);

    // Reset lands in the 4th RUN cycle
    @(posedge clk); #1;
    iv1 = 1'b1; a1 = 8'h55; b1 = 8'h2A; c1 = 1'b0;
    @(posedge clk); #1 iv1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_val("t4_rst", {ir1, ov1, s1}, {1'b1, 1'b0, 8'h00});
    @(negedge clk) rst = 1'b0;
    run_op("t4_next", 8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0, 1'b0, 8);

    // BITS_PER_CYCLE=4
    @(posedge clk); #1;
    iv4 = 1'b1; a4 = 8'h9C; b4 = 8'h67; c4 = 1'b1;
    @(posedge clk); #1 iv4 = 1'b0;
    k = 0;
    do begin
      @(posedge clk); k++;
      @(negedge clk);
    end while (!ov4 && k < 40);
    check_val("t5_lat", k, 2);
    check_val("t5_res", {of4, co4, s4}, {1'b0, 1'b1, 8'h04});
    @(posedge clk); #1 or4 = 1'b1;
    @(posedge clk); #1 or4 = 1'b0;
    @(negedge clk);
    check_val("t5_handoff", {ir4, ov4}, 2'b10);

    rand_go = 1'b1;
    fork
      begin : drv1
        int n, cyc;
        n = 0; cyc = 0;
        while (n < 2000 && cyc < LIMIT) begin
          @(posedge clk); #1;
          iv1 = 1'($urandom_range(0, 1)); a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
          @(negedge clk);
          if (iv1 && ir1) begin
            q1.push_back(model(a1, b1, c1));
            n++;
          end
          cyc++;
        end
        @(posedge clk); #1 iv1 = 1'b0;
      end
      begin : mon1
        int got, cyc;
        logic [9:0] e;
        got = 0; cyc = 0;
        while (got < 2000 && cyc < LIMIT) begin
          @(posedge clk); #1;
          or1 = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (ov1 && or1) begin
            if (q1.size() == 0) check_val("rand_bpc1_extra", 1, 0);
            else begin
              e = q1.pop_front();
              check_val("rand_bpc1", {of1, co1, s1}, e);
            end
            got++;
          end
          cyc++;
        end
        check_val("rand_bpc1_count", got, 2000);
        @(posedge clk); #1 or1 = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rand_bpc1_left", q1.size(), 0);

    k = 0;
    while (!(g[0].done_f && g[1].done_f) && k < LIMIT) begin
      @(posedge clk); k++;
    end
    check_val("rand_done", {g[0].done_f, g[1].done_f}, 2'b11);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
